// File: rtl/arm_mc_datapath.sv
// rtl/arm_mc_datapath.sv - multicycle ARM datapath with shared memory port and MemReady stall
module arm_mc_datapath #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             AdrSrc,
    input  logic             IRWrite,
    input  logic             MemReady,
    input  logic             RegWrite,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ImmSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [2:0]       ALUControl,
    input  logic [1:0]       ResultSrc,
    input  logic             LSrc,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    output logic             Stall,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData
);

    // Bytes per word: PC increment and the R15 read offset
    localparam logic [WIDTH-1:0] C_STEP = WIDTH'(WIDTH / 8);

    logic [WIDTH-1:0] r_pc;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_aluout;
    logic [WIDTH-1:0] r_rf [0:15];

    logic             w_stall;
    logic [3:0]       w_ra1;
    logic [3:0]       w_ra2;
    logic [3:0]       w_wa;
    logic [WIDTH-1:0] w_wd;
    logic             w_we;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [4:0]       w_shamt;
    logic [6:0]       w_rot_amt;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_ext_imm;
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_b_arith;
    logic [WIDTH:0]   w_sum;
    logic             w_is_sub;
    logic             w_is_arith;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_flag_c;
    logic             w_flag_v;
    logic [WIDTH-1:0] w_result;

    // A fetch waiting on memory freezes all architectural progress
    assign w_stall = IRWrite & ~MemReady;
    assign Stall   = w_stall;

    assign Instr     = r_ir;
    assign WriteData = r_b;
    assign Adr       = AdrSrc ? r_aluout : r_pc;

    // Register addressing; R15 reads see the already-advanced PC plus one word
    assign w_ra1 = RegSrc[0] ? 4'd15 : r_ir[19:16];
    assign w_ra2 = RegSrc[1] ? r_ir[15:12] : r_ir[3:0];
    assign w_rd1 = (w_ra1 == 4'd15) ? (r_pc + C_STEP) : r_rf[w_ra1];
    assign w_rd2 = (w_ra2 == 4'd15) ? (r_pc + C_STEP) : r_rf[w_ra2];

    // Link writes the PC into R14; otherwise Result goes to Rd
    assign w_wa = LSrc ? 4'd14 : r_ir[15:12];
    assign w_wd = LSrc ? r_pc : w_result;
    assign w_we = RegWrite & ~w_stall & ~reset & (w_wa != 4'd15);

    // Immediate-amount barrel shifter on B; amount 0 or an immediate operand passes B through
    always_comb begin
        w_shamt   = r_ir[11:7];
        w_rot_amt = 7'(WIDTH) - {2'b00, w_shamt};
        w_shifted = r_b;
        if (!r_ir[25] && (w_shamt != 5'd0)) begin
            case (r_ir[6:5])
                2'b00:   w_shifted = r_b << w_shamt;
                2'b01:   w_shifted = r_b >> w_shamt;
                2'b10:   w_shifted = WIDTH'($signed(r_b) >>> w_shamt);
                default: w_shifted = (r_b >> w_shamt) | (r_b << w_rot_amt);
            endcase
        end
    end

    // Immediate extension to the full datapath width
    always_comb begin
        case (ImmSrc)
            2'b00:   w_ext_imm = {{(WIDTH-8){1'b0}}, r_ir[7:0]};
            2'b01:   w_ext_imm = {{(WIDTH-12){1'b0}}, r_ir[11:0]};
            2'b10:   w_ext_imm = {{(WIDTH-26){r_ir[23]}}, r_ir[23:0], 2'b00};
            default: w_ext_imm = '0;
        endcase
    end

    // ALU operand selection
    always_comb begin
        w_src_a = ALUSrcA ? r_pc : r_a;
        case (ALUSrcB)
            2'b00:   w_src_b = w_shifted;
            2'b01:   w_src_b = w_ext_imm;
            2'b10:   w_src_b = C_STEP;
            default: w_src_b = '0;
        endcase
    end

    // ALU: subtract is add of the inverted operand plus one, so carry is NOT borrow
    always_comb begin
        w_is_sub   = (ALUControl == 3'b001);
        w_is_arith = (ALUControl[2:1] == 2'b00);
        w_b_arith  = w_is_sub ? ~w_src_b : w_src_b;
        w_sum      = {1'b0, w_src_a} + {1'b0, w_b_arith} + {{WIDTH{1'b0}}, w_is_sub};
        case (ALUControl)
            3'b000,
            3'b001:  w_alu_result = w_sum[WIDTH-1:0];
            3'b010:  w_alu_result = w_src_a & w_src_b;
            3'b011:  w_alu_result = w_src_a | w_src_b;
            3'b100:  w_alu_result = w_src_a ^ w_src_b;
            default: w_alu_result = '0;
        endcase
        w_flag_c = w_is_arith & w_sum[WIDTH];
        w_flag_v = w_is_arith & (w_src_a[WIDTH-1] == w_b_arith[WIDTH-1])
                              & (w_sum[WIDTH-1] != w_src_a[WIDTH-1]);
    end

    assign ALUFlags = {w_alu_result[WIDTH-1], (w_alu_result == '0), w_flag_c, w_flag_v};

    // Result bus feeding PC and register file
    always_comb begin
        case (ResultSrc)
            2'b01:   w_result = r_data;
            2'b10:   w_result = w_alu_result;
            default: w_result = r_aluout;
        endcase
    end

    // Nonarchitectural registers and PC; Data keeps sampling through a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (MemReady) begin
                r_data <= ReadData;
            end
            if (!w_stall) begin
                if (IRWrite) begin
                    r_ir <= ReadData[31:0];
                end
                if (PCWrite) begin
                    r_pc <= w_result;
                end
                r_a      <= w_rd1;
                r_b      <= w_rd2;
                r_aluout <= w_alu_result;
            end
        end
    end

    // Register file write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_rf[w_wa] <= w_wd;
        end
    end

endmodule

// File: tb/tb_arm_mc_datapath.sv
// tb/tb_arm_mc_datapath.sv - directed self-checking bench for arm_mc_datapath at WIDTH 32 and 64
module tb_arm_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCWrite, AdrSrc, IRWrite, MemReady, RegWrite, ALUSrcA, LSrc;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [2:0]  ALUControl;
    logic [31:0] rd;

    logic [31:0] instr32, instr64;
    logic [3:0]  flags32, flags64;
    logic        stall32, stall64;
    logic [31:0] adr32, wd32;
    logic [63:0] adr64, wd64;
    logic [63:0] rd64;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt;

    logic [31:0] sh_ir  [6];
    logic [31:0] sh_b   [6];
    logic [31:0] sh_e32 [6];
    logic [63:0] sh_e64 [6];

    always #5 clk = ~clk;

    assign rd64 = {32'h0, rd};

    arm_mc_datapath #(.WIDTH(32), .RESET_PC(32'h100)) u32 (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemReady(MemReady), .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .LSrc(LSrc), .Instr(instr32), .ALUFlags(flags32), .Stall(stall32), .Adr(adr32),
        .WriteData(wd32), .ReadData(rd)
    );

    arm_mc_datapath #(.WIDTH(64), .RESET_PC(64'h100)) u64 (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemReady(MemReady), .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .LSrc(LSrc), .Instr(instr64), .ALUFlags(flags64), .Stall(stall64), .Adr(adr64),
        .WriteData(wd64), .ReadData(rd64)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl_clear();
        PCWrite = 0; AdrSrc = 0; IRWrite = 0; MemReady = 1; RegWrite = 0; LSrc = 0;
        RegSrc = 2'b00; ImmSrc = 2'b00; ALUSrcA = 0; ALUSrcB = 2'b00;
        ALUControl = 3'b000; ResultSrc = 2'b00;
    endtask

    task automatic load_ir(input logic [31:0] v);
        ctrl_clear();
        IRWrite = 1;
        rd = v;
        step();
        IRWrite = 0;
    endtask

    // Writes v into the register named by Instr[15:12] through the Data register
    task automatic set_rd(input logic [31:0] v);
        ctrl_clear();
        rd = v;
        step();
        RegWrite  = 1;
        ResultSrc = 2'b01;
        step();
        RegWrite  = 0;
        ResultSrc = 2'b00;
    endtask

    initial begin
        sh_ir[0] = 32'hE0021240; sh_b[0] = 32'h80000000; sh_e32[0] = 32'hF8000000; sh_e64[0] = 64'h08000000;
        sh_ir[1] = 32'hE0021220; sh_b[1] = 32'h80000000; sh_e32[1] = 32'h08000000; sh_e64[1] = 64'h08000000;
        sh_ir[2] = 32'hE0021260; sh_b[2] = 32'h80000000; sh_e32[2] = 32'h08000000; sh_e64[2] = 64'h08000000;
        sh_ir[3] = 32'hE0021000; sh_b[3] = 32'h80000000; sh_e32[3] = 32'h80000000; sh_e64[3] = 64'h80000000;
        sh_ir[4] = 32'hE0021260; sh_b[4] = 32'h0000000F; sh_e32[4] = 32'hF0000000; sh_e64[4] = 64'hF000000000000000;
        sh_ir[5] = 32'hE0021200; sh_b[5] = 32'h0000000F; sh_e32[5] = 32'h000000F0; sh_e64[5] = 64'h000000F0;

        ctrl_clear();
        rd = 32'h0;
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
        check_eq("rst_instr", {32'h0, instr32}, 64'h0);
        check_eq("rst_adr32", {32'h0, adr32}, 64'h100);
        check_eq("rst_adr64", adr64, 64'h100);
        check_eq("rst_stall", {63'h0, stall32}, 64'h0);
        check_eq("rst_flags", {60'h0, flags32}, 64'h4);
        check_eq("rst_wdata", {32'h0, wd32}, 64'h0);
        IRWrite = 1; MemReady = 0;
        #1;
        check_eq("rst_stall_follows_irwrite", {63'h0, stall32}, 64'h1);

        // Fetch held off for three cycles by MemReady
        PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
        rd = 32'hE2811005;
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall32) stall_cnt++;
            step();
            check_eq("stall_pc_hold", {32'h0, adr32}, 64'h100);
        end
        check_eq("stall_cycles", 64'(stall_cnt), 64'd3);
        check_eq("stall_ir_hold", {32'h0, instr32}, 64'h0);
        MemReady = 1;
        #1;
        check_eq("fetch_stall_low", {63'h0, stall32}, 64'h0);
        step();
        check_eq("fetch_ir", {32'h0, instr32}, 64'hE2811005);
        check_eq("fetch_pc32", {32'h0, adr32}, 64'h104);
        check_eq("fetch_pc64", adr64, 64'h108);

        // ADD R1,R1,#5 with R1=7
        set_rd(32'd7);
        step();
        ALUSrcB = 2'b01;
        #1;
        check_eq("add_flags", {60'h0, flags32}, 64'h0);
        step();
        AdrSrc = 1;
        #1;
        check_eq("add_aluout", {32'h0, adr32}, 64'd12);
        RegWrite = 1;
        step();
        RegWrite = 0;
        step();
        step();
        check_eq("add_r1_wb32", {32'h0, adr32}, 64'd17);
        check_eq("add_r1_wb64", adr64, 64'd17);

        // Flags: SUB 5-5, logic ops, overflow and carry-out
        set_rd(32'd5);
        RegSrc = 2'b10;
        step();
        ALUControl = 3'b001;
        #1;
        check_eq("sub_flags32", {60'h0, flags32}, 64'h6);
        check_eq("sub_flags64", {60'h0, flags64}, 64'h6);
        ALUControl = 3'b010;
        #1;
        check_eq("and_flags", {60'h0, flags32}, 64'h0);
        ALUControl = 3'b100;
        #1;
        check_eq("eor_flags", {60'h0, flags32}, 64'h4);

        load_ir(32'hE2811001);
        set_rd(32'h7FFFFFFF);
        step();
        ALUSrcB = 2'b01;
        #1;
        check_eq("ovf_flags32", {60'h0, flags32}, 64'h9);
        check_eq("ovf_flags64", {60'h0, flags64}, 64'h0);
        set_rd(32'hFFFFFFFF);
        step();
        ALUSrcB = 2'b01;
        #1;
        check_eq("carry_flags32", {60'h0, flags32}, 64'h6);
        check_eq("carry_flags64", {60'h0, flags64}, 64'h0);

        // Shifter: R2=0 as the ORR partner, R1 holds the value being shifted
        load_ir(32'hE0002000);
        set_rd(32'h0);
        for (int i = 0; i < 6; i++) begin
            load_ir(sh_ir[i]);
            set_rd(sh_b[i]);
            RegSrc = 2'b10;
            step();
            ALUControl = 3'b011;
            step();
            AdrSrc = 1;
            #1;
            check_eq($sformatf("shift%0d_w32", i), {32'h0, adr32}, {32'h0, sh_e32[i]});
            check_eq($sformatf("shift%0d_w64", i), adr64, sh_e64[i]);
        end

        // BL: PC=0x200, link into R14, then R15-R14 and the branch target
        load_ir(32'hEBFFFFFE);
        ctrl_clear();
        rd = 32'h200;
        step();
        PCWrite = 1; ResultSrc = 2'b01;
        step();
        PCWrite = 0; ResultSrc = 2'b00;
        #1;
        check_eq("bl_pc32", {32'h0, adr32}, 64'h200);
        check_eq("bl_pc64", adr64, 64'h200);
        RegWrite = 1; LSrc = 1;
        step();
        RegWrite = 0; LSrc = 0; RegSrc = 2'b01;
        step();
        ALUControl = 3'b001;
        #1;
        check_eq("bl_r14_w32", {32'h0, wd32}, 64'h200);
        check_eq("bl_r14_w64", wd64, 64'h200);
        check_eq("bl_sub_flags", {60'h0, flags32}, 64'h2);
        step();
        AdrSrc = 1;
        #1;
        check_eq("r15_minus_r14_w32", {32'h0, adr32}, 64'h4);
        check_eq("r15_minus_r14_w64", adr64, 64'h8);
        ALUSrcA = 1; ALUSrcB = 2'b01; ImmSrc = 2'b10; ALUControl = 3'b000;
        step();
        check_eq("bl_target32", {32'h0, adr32}, 64'h1F8);
        check_eq("bl_target64", adr64, 64'h1F8);
        AdrSrc = 0;
        #1;
        check_eq("bl_pc_kept", {32'h0, adr32}, 64'h200);

        // Reset arriving during a stalled fetch
        ctrl_clear();
        IRWrite = 1; MemReady = 0; reset = 1;
        #1;
        check_eq("rst_mid_stall_pre", {63'h0, stall32}, 64'h1);
        step();
        reset = 0;
        #1;
        check_eq("rst_mid_stall_pc", {32'h0, adr32}, 64'h100);
        check_eq("rst_mid_stall_ir", {32'h0, instr32}, 64'h0);
        check_eq("rst_mid_stall_on", {63'h0, stall32}, 64'h1);
        IRWrite = 0;
        #1;
        check_eq("rst_mid_stall_off", {63'h0, stall64}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arm_mc_datapath.md
Name: arm_mc_datapath

Overview:
- Parametrised multicycle successor to the single-cycle ARM datapath.
- Shares one memory port for instruction and data: one address output, with a MemReady handshake.
- Holds nonarchitectural registers IR, Data, A, B and ALUOut, the 16-entry register file, the PC and an immediate-amount barrel shifter.
- Sits between the multicycle controller FSM, which drives every control input, and unified memory.

Parameters:
WIDTH, 32, datapath word width; legal values 32 or 64. Instruction is always 32 bits.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
PCWrite  in  1  PC load enable
AdrSrc  in  1  memory address select: 0=PC, 1=ALUOut
IRWrite  in  1  instruction register load enable; marks a fetch cycle
MemReady  in  1  memory has valid ReadData / accepted the write this cycle
RegWrite  in  1  register file write enable
RegSrc  in  2  [0] RA1=R15, [1] RA2=Instr[15:12]
ImmSrc  in  2  00 imm8 zero-ext, 01 imm12 zero-ext, 10 imm24<<2 sign-ext
ALUSrcA  in  1  0=A, 1=PC
ALUSrcB  in  2  00 shifted B, 01 ExtImm, 10 constant WIDTH/8
ALUControl  in  3  ALU op: 000 add, 001 sub, 010 and, 011 orr, 100 eor
ResultSrc  in  2  00 ALUOut, 01 Data, 10 ALUResult
LSrc  in  1  link: write PC to R14
Instr  out  32  IR contents
ALUFlags  out  4  NZCV of the current ALU result (combinational)
Stall  out  1  IRWrite & ~MemReady
Adr  out  WIDTH  memory address
WriteData  out  WIDTH  B register, store data
ReadData  in  WIDTH  memory read data

Behaviour:
- Reset (synchronous, active-high) loads PC=RESET_PC and sets IR, Data, A, B and ALUOut to 0. Register file contents are not reset.
- Outputs after reset: Instr=0, Stall=IRWrite, Adr=RESET_PC when AdrSrc=0.
- Stall=1 freezes PC, IR, A, B, ALUOut and register-file writes; Data still samples. Only reset overrides a stall.
- With Stall=0, each rising edge does:
  - IR <= ReadData[31:0] when IRWrite=1.
  - Data <= ReadData when MemReady=1.
  - PC <= Result when PCWrite=1.
  - A <= RD1 and B <= RD2, unconditionally.
  - ALUOut <= ALUResult, unconditionally.
- Register write: when RegWrite=1, write Result to Instr[15:12]. When LSrc=1 as well, write PC to R14 instead. A write to R15 is ignored; the PC is updated only through PCWrite.
- Register reads are combinational. A read of R15 returns PC + WIDTH/8; the PC has already advanced in fetch, so this equals instruction address + 8 for WIDTH=32.
- RA1 = RegSrc[0] ? 15 : Instr[19:16]. RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
- Shifter operates on B when Instr[25]=0.
  - Amount is Instr[11:7]; type is Instr[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Amount 0 passes B through unchanged for every type.
  - ROR rotates within WIDTH bits.
  - When Instr[25]=1 the shifter output equals B.
- ALU arithmetic is WIDTH-bit.
  - C = carry-out for add and NOT borrow for sub. V = signed overflow for add/sub.
  - For logic ops, C=0 and V=0.
  - N = result MSB. Z = result is all zeros.
- ExtImm is always extended to WIDTH bits.
- Typical fetch→decode→execute→writeback = 4 cycles with MemReady held high. Each cycle of MemReady=0 in a fetch adds exactly one cycle.
- Reset asserted mid-stall: the next edge applies reset, and the stall ends once IRWrite drops.
- Register-file write and read of the same register in the same cycle: the read returns the old value; the new value is visible the next cycle.

Test Plan:
- Reset with RESET_PC=0x100, then a fetch (IRWrite=1, PCWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, MemReady=1, ReadData=0xE2811005) -> IR=0xE2811005, PC=0x104, Stall=0.
- Same fetch with MemReady=0 for 3 cycles and then 1 -> Stall high for exactly 3 cycles; PC holds 0x100 throughout; IR loads on the 4th edge.
- ADD R1,R1,#5 with R1=7, run through execute and writeback -> R1=12; ALUFlags=0000.
- SUB with A=5, B=5 -> ALUFlags N=0, Z=1, C=1, V=0. A=0x7FFFFFFF ADD 1 -> N=1, V=1.
- Shifter with B=0x80000000: ASR #4 -> 0xF8000000; LSR #4 -> 0x08000000; ROR #4 -> 0x08000000; LSL #0 -> 0x80000000.
- BL at PC=0x200 with LSrc=1 and RegWrite=1 -> R14=PC register value. A read of R15 returns 0x204. Repeat with WIDTH=64: PC steps by 8.
